stack_wb_unit: RTL and testbench
================================

Name: stack_wb_unit

Overview:
- Stage-5 write-back and stack unit of the 8-bit pipelined RISC core.
- Sits directly downstream of the stage-4 control code generator and consumes its WR, LRN, LR0, LSP, DSP, ISP, LOP and ERN strobes.
- Owns the stack pointer, the register-file write-back strobes, the output-port latches, and a req/ack handshake to data memory.
- Stalls the pipeline while a memory write is outstanding.

Parameters:
- DATA_W, 8, datapath and address width.
- SP_RESET, 8'hFF, stack pointer value after reset.
- NUM_PORTS, 8, number of output-port latches, indexed by port_sel.

Ports:
- clk  in  1  global clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  memory write request from stage 4.
- lrn  in  1  load Rn.
- lr0  in  1  load R0.
- lsp  in  1  load SP from alu_result.
- dsp  in  1  post-decrement SP (push/call).
- isp  in  1  pre-increment SP (pop/return).
- lop  in  1  load output port.
- ern  in  1  route alu_result (1) or operand od (0) to Rn write data.
- rn_sel  in  3  destination register index.
- port_sel  in  3  output-port index.
- alu_result  in  DATA_W  result bus.
- od  in  DATA_W  operand/direct address.
- mem_ack  in  1  data-memory write acknowledge.
- mem_we  out  1  memory write strobe, held until ack.
- mem_addr  out  DATA_W  write address.
- mem_wdata  out  DATA_W  write data.
- stall  out  1  freeze upstream stages.
- sp  out  DATA_W  current stack pointer.
- stack_rd_addr  out  DATA_W  combinational sp+1, address for pop/return reads.
- rn_we  out  1  Rn write enable.
- rn_addr  out  3  Rn write address.
- rn_wdata  out  DATA_W  Rn write data.
- r0_we  out  1  R0 write enable.
- r0_wdata  out  DATA_W  R0 write data.
- out_port  out  NUM_PORTS*DATA_W  flattened output-port latches.
- out_strobe  out  NUM_PORTS  one-cycle pulse per updated port.

Behaviour:
- Reset (asynchronous, immediate):
  - sp = SP_RESET.
  - FSM = IDLE.
  - mem_we, rn_we, r0_we, stall and out_strobe = 0.
  - mem_addr, mem_wdata, rn_addr, rn_wdata, r0_wdata and out_port = 0.
  - A reset during WRITE drops mem_we in the same instant; the aborted write is not retried.
- FSM has two states, IDLE and WRITE.
- IDLE samples all control inputs every cycle.
- wr=1 in IDLE, on the next edge:
  - Enter WRITE and assert mem_we.
  - mem_addr = dsp ? sp (pre-update value) : od.
  - mem_wdata = alu_result.
- WRITE:
  - mem_we=1 and stall=1 (combinational on state).
  - Control inputs are ignored; upstream holds them because of stall.
  - mem_ack=1 returns the FSM to IDLE on that edge; mem_we=0 the following cycle.
  - mem_ack already high on the first WRITE cycle means a 1-cycle write.
  - mem_ack while in IDLE is ignored.
- SP update happens only on the IDLE accept edge and is never repeated while in WRITE. Priority:
  - lsp: sp <= alu_result.
  - dsp only: sp <= sp-1.
  - isp only: sp <= sp+1.
  - dsp and isp together: sp unchanged.
  - Arithmetic is modulo 2^DATA_W: 8'h00-1 = 8'hFF, 8'hFF+1 = 8'h00.
- Write-back is registered with 1-cycle latency and forced to 0 while in WRITE.
  - lrn: rn_we=1, rn_addr=rn_sel, rn_wdata = ern ? alu_result : od.
  - lr0: r0_we=1, r0_wdata=alu_result.
  - lrn and lr0 together: both fire.
  - rn_sel=0 with lr0 also set: both ports drive, and the register file gives R0 priority.
- lop: out_port[port_sel] <= alu_result and out_strobe[port_sel] pulses for 1 cycle. The other ports hold their values.
- Write-back and output-port updates are accepted in the same IDLE cycle as wr. They are not delayed by the memory handshake.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined:
  - Adds output sp_fault (1 bit, sticky, cleared only by rst).
  - A dsp at sp=8'h00 or an isp at sp=8'hFF sets sp_fault.
  - The faulting update is suppressed, so sp holds.
  - A push write still occurs at the unchanged sp.
- Undefined: no sp_fault port, and sp wraps silently.

Decomposition:
- Shared package core_pkg holds:
  - DATA_W.
  - FSM state encoding (ST_IDLE=1'b0, ST_WRITE=1'b1).
  - SP_RESET default.
- One natural sub-module: stack_pointer_reg. It holds the SP register, the lsp/dsp/isp priority logic, the wrap/guard logic and the sp+1 output.
- The FSM, write-back and port latches stay in the top module.

Test Plan:
- Reset check: after rst, sp=8'hFF and mem_we=0. Asserting rst mid-WRITE with mem_ack=0 drops mem_we and stall immediately, and sp returns to 8'hFF.
- Push: dsp=1, wr=1, sp=8'h80, alu_result=8'h5A. Required: mem_addr=8'h80, mem_wdata=8'h5A, sp=8'h7F. With mem_ack delayed 3 cycles, stall stays high for exactly 3 cycles and then mem_we=0.
- Pop: isp=1, lrn=1, ern=1, rn_sel=3, alu_result=8'h11 at sp=8'h7F. Required: sp=8'h80 and stack_rd_addr=8'h80 before the edge; one cycle later rn_we=1, rn_addr=3, rn_wdata=8'h11.
- Wrap: dsp at sp=8'h00. Without STACK_GUARD_EN, sp=8'hFF. With STACK_GUARD_EN, sp stays 8'h00 and sp_fault=1 until rst.
- Priority and output: lsp=1, dsp=1, alu_result=8'h40 gives sp=8'h40. Then lop=1, port_sel=5, alu_result=8'hC3 gives out_port[5]=8'hC3, a single-cycle out_strobe[5] pulse, and the other ports unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared widths, FSM encoding and reset constants for the stage-5 stack/write-back unit.
package core_pkg;
    localparam int DATA_W = 8;
    localparam logic [7:0] SP_RESET = 8'hFF;
    typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;
endpackage

// File: rtl/stack_pointer_reg.sv
// stack_pointer_reg: SP register with lsp/dsp/isp priority, modulo wrap and sp+1 read address.
// STACK_GUARD_EN adds a sticky sp_fault and suppresses underflow/overflow updates.
module stack_pointer_reg #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter logic [DATA_W-1:0] SP_RESET = core_pkg::SP_RESET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              lsp,
    input  logic              dsp,
    input  logic              isp,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] sp_inc
`ifdef STACK_GUARD_EN
    ,
    output logic              sp_fault
`endif
);
    logic dec, inc;
    logic [DATA_W-1:0] sp_next;
    assign dec = dsp & ~isp & ~lsp;
    assign inc = isp & ~dsp & ~lsp;
    assign sp_inc = sp + 1'b1;
`ifdef STACK_GUARD_EN
    logic fault;
    assign fault = (dec && sp == '0) || (inc && sp == '1);
    always_ff @(posedge clk or posedge rst)
        if (rst) sp_fault <= 1'b0;
        else if (en && fault) sp_fault <= 1'b1;
`else
    localparam logic fault = 1'b0;
`endif
    // dsp together with isp cancels out and leaves sp unchanged
    always_comb sp_next = lsp ? alu_result : (dec && !fault) ? sp - 1'b1 : (inc && !fault) ? sp_inc : sp;
    always_ff @(posedge clk or posedge rst)
        if (rst) sp <= SP_RESET;
        else if (en) sp <= sp_next;
endmodule

// File: rtl/stack_wb_unit.sv
// stack_wb_unit: stage-5 write-back, stack pointer, output ports and data-memory write handshake.
// Optional STACK_GUARD_EN exposes sp_fault for stack under/overflow.
module stack_wb_unit #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter logic [DATA_W-1:0] SP_RESET = core_pkg::SP_RESET,
    parameter int NUM_PORTS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr,
    input  logic                        lrn,
    input  logic                        lr0,
    input  logic                        lsp,
    input  logic                        dsp,
    input  logic                        isp,
    input  logic                        lop,
    input  logic                        ern,
    input  logic [2:0]                  rn_sel,
    input  logic [2:0]                  port_sel,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic [DATA_W-1:0]           od,
    input  logic                        mem_ack,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        stall,
    output logic [DATA_W-1:0]           sp,
    output logic [DATA_W-1:0]           stack_rd_addr,
    output logic                        rn_we,
    output logic [2:0]                  rn_addr,
    output logic [DATA_W-1:0]           rn_wdata,
    output logic                        r0_we,
    output logic [DATA_W-1:0]           r0_wdata,
    output logic [NUM_PORTS*DATA_W-1:0] out_port,
    output logic [NUM_PORTS-1:0]        out_strobe
`ifdef STACK_GUARD_EN
    ,
    output logic                        sp_fault
`endif
);
    import core_pkg::*;
    state_t state;
    logic idle;
    assign idle = state == ST_IDLE;
    assign stall = state == ST_WRITE;
    assign mem_we = stall;

    stack_pointer_reg #(.DATA_W(DATA_W), .SP_RESET(SP_RESET)) u_sp (
        .clk(clk),
        .rst(rst),
        .en(idle),
        .lsp(lsp),
        .dsp(dsp),
        .isp(isp),
        .alu_result(alu_result),
        .sp(sp),
        .sp_inc(stack_rd_addr)
`ifdef STACK_GUARD_EN
        ,
        .sp_fault(sp_fault)
`endif
    );

    // write-back and port updates ride the same accept edge as wr, independent of the handshake
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            mem_addr <= '0;
            mem_wdata <= '0;
            rn_we <= 1'b0;
            rn_addr <= '0;
            rn_wdata <= '0;
            r0_we <= 1'b0;
            r0_wdata <= '0;
            out_port <= '0;
            out_strobe <= '0;
        end else begin
            rn_we <= idle & lrn;
            r0_we <= idle & lr0;
            out_strobe <= '0;
            if (idle) begin
                if (wr) begin
                    state <= ST_WRITE;
                    mem_addr <= dsp ? sp : od;
                    mem_wdata <= alu_result;
                end
                if (lrn) begin
                    rn_addr <= rn_sel;
                    rn_wdata <= ern ? alu_result : od;
                end
                if (lr0) r0_wdata <= alu_result;
                if (lop) begin
                    out_port[port_sel*DATA_W +: DATA_W] <= alu_result;
                    out_strobe[port_sel] <= 1'b1;
                end
            end else if (mem_ack) state <= ST_IDLE;
        end
endmodule

// File: tb/tb_stack_wb_unit.sv
// tb_stack_wb_unit: scoreboarded bench for stack_wb_unit; honours STACK_GUARD_EN for the wrap case.
module tb_stack_wb_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic wr, lrn, lr0, lsp, dsp, isp, lop, ern, mem_ack;
    logic [2:0] rn_sel, port_sel;
    logic [7:0] alu_result, od;
    logic mem_we, stall, rn_we, r0_we;
    logic [7:0] mem_addr, mem_wdata, sp, stack_rd_addr, rn_wdata, r0_wdata;
    logic [2:0] rn_addr;
    logic [63:0] out_port;
    logic [7:0] out_strobe;
`ifdef STACK_GUARD_EN
    logic sp_fault;
`endif
    int checks = 0, failures = 0;
    logic [15:0] mem_q[$];

    always #5 clk = ~clk;

    stack_wb_unit dut (
        .clk(clk), .rst(rst), .wr(wr), .lrn(lrn), .lr0(lr0), .lsp(lsp), .dsp(dsp), .isp(isp),
        .lop(lop), .ern(ern), .rn_sel(rn_sel), .port_sel(port_sel), .alu_result(alu_result), .od(od),
        .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall),
        .sp(sp), .stack_rd_addr(stack_rd_addr), .rn_we(rn_we), .rn_addr(rn_addr), .rn_wdata(rn_wdata),
        .r0_we(r0_we), .r0_wdata(r0_wdata), .out_port(out_port), .out_strobe(out_strobe)
`ifdef STACK_GUARD_EN
        , .sp_fault(sp_fault)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {wr, lrn, lr0, lsp, dsp, isp, lop, ern, mem_ack} = '0;
        rn_sel = 3'd0; port_sel = 3'd0; alu_result = 8'h00; od = 8'h00;
    endtask

    task automatic load_sp(input logic [7:0] v);
        lsp = 1'b1; alu_result = v;
        tick();
        lsp = 1'b0;
        checks++;
        if (sp !== v) begin failures++; $display("FAIL load_sp got=%h exp=%h", sp, v); end
    endtask

    task automatic check_mem_txn(input string name);
        logic [15:0] exp;
        checks++;
        if (mem_q.size() == 0) begin
            failures++; $display("FAIL %s scoreboard empty got=%h/%h", name, mem_addr, mem_wdata);
        end else begin
            exp = mem_q.pop_front();
            if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== exp) begin
                failures++;
                $display("FAIL %s we=%b addr/data got=%h/%h exp=%h/%h", name, mem_we, mem_addr, mem_wdata, exp[15:8], exp[7:0]);
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (sp !== 8'hFF || mem_we !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL reset sp=%h we=%b stall=%b exp sp=ff we=0 stall=0", sp, mem_we, stall);
        end
        checks++;
        if (out_port !== 64'd0 || out_strobe !== 8'd0 || rn_we !== 1'b0 || r0_we !== 1'b0 || mem_addr !== 8'd0) begin
            failures++; $display("FAIL reset_regs port=%h strobe=%h rn_we=%b r0_we=%b addr=%h exp all zero", out_port, out_strobe, rn_we, r0_we, mem_addr);
        end
    endtask

    task automatic test_push();
        int cnt = 0;
        load_sp(8'h80);
        dsp = 1'b1; wr = 1'b1; alu_result = 8'h5A;
        mem_q.push_back({8'h80, 8'h5A});
        tick();
        check_mem_txn("push_txn");
        checks++;
        if (sp !== 8'h7F || stall !== 1'b1) begin
            failures++; $display("FAIL push_sp sp=%h stall=%b exp sp=7f stall=1", sp, stall);
        end
        for (int i = 0; i < 10 && stall; i++) begin
            cnt++;
            if (cnt == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0; dsp = 1'b0; wr = 1'b0;
        checks++;
        if (cnt !== 3 || mem_we !== 1'b0) begin
            failures++; $display("FAIL push_stall cycles=%0d we=%b exp cycles=3 we=0", cnt, mem_we);
        end
        checks++;
        if (sp !== 8'h7F) begin failures++; $display("FAIL push_sp_once sp=%h exp=7f", sp); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL idle_ack we=%b stall=%b exp 0/0", mem_we, stall);
        end
    endtask

    task automatic test_pop();
        isp = 1'b1; lrn = 1'b1; ern = 1'b1; rn_sel = 3'd3; alu_result = 8'h11;
        checks++;
        if (stack_rd_addr !== 8'h80) begin failures++; $display("FAIL pop_rd_addr got=%h exp=80", stack_rd_addr); end
        tick();
        clear_inputs();
        checks++;
        if (sp !== 8'h80 || rn_we !== 1'b1 || rn_addr !== 3'd3 || rn_wdata !== 8'h11) begin
            failures++; $display("FAIL pop_wb sp=%h we=%b addr=%0d data=%h exp 80/1/3/11", sp, rn_we, rn_addr, rn_wdata);
        end
        lrn = 1'b1; lr0 = 1'b1; ern = 1'b0; rn_sel = 3'd0; od = 8'h22; alu_result = 8'h33;
        tick();
        clear_inputs();
        checks++;
        if (rn_we !== 1'b1 || rn_addr !== 3'd0 || rn_wdata !== 8'h22 || r0_we !== 1'b1 || r0_wdata !== 8'h33) begin
            failures++; $display("FAIL dual_wb rn=%b/%0d/%h r0=%b/%h exp 1/0/22 1/33", rn_we, rn_addr, rn_wdata, r0_we, r0_wdata);
        end
        tick();
        checks++;
        if (rn_we !== 1'b0 || r0_we !== 1'b0) begin failures++; $display("FAIL wb_pulse rn_we=%b r0_we=%b exp 0/0", rn_we, r0_we); end
    endtask

    task automatic test_wrap();
        load_sp(8'h00);
        dsp = 1'b1;
        tick();
        dsp = 1'b0;
`ifdef STACK_GUARD_EN
        checks++;
        if (sp !== 8'h00 || sp_fault !== 1'b1) begin failures++; $display("FAIL guard_dec sp=%h fault=%b exp 00/1", sp, sp_fault); end
        tick();
        checks++;
        if (sp_fault !== 1'b1) begin failures++; $display("FAIL guard_sticky fault=%b exp=1", sp_fault); end
`else
        checks++;
        if (sp !== 8'hFF) begin failures++; $display("FAIL wrap_dec sp=%h exp=ff", sp); end
        isp = 1'b1;
        tick();
        isp = 1'b0;
        checks++;
        if (sp !== 8'h00) begin failures++; $display("FAIL wrap_inc sp=%h exp=00", sp); end
`endif
    endtask

    task automatic test_priority_output();
        lsp = 1'b1; dsp = 1'b1; alu_result = 8'h40;
        tick();
        lsp = 1'b0; isp = 1'b1;
        checks++;
        if (sp !== 8'h40) begin failures++; $display("FAIL lsp_priority sp=%h exp=40", sp); end
        tick();
        clear_inputs();
        checks++;
        if (sp !== 8'h40) begin failures++; $display("FAIL dsp_isp_cancel sp=%h exp=40", sp); end
        lop = 1'b1; port_sel = 3'd5; alu_result = 8'hC3;
        tick();
        clear_inputs();
        checks++;
        if (out_port[47:40] !== 8'hC3 || out_strobe !== 8'b0010_0000 || (out_port & ~(64'hFF << 40)) !== 64'd0) begin
            failures++; $display("FAIL port5 port=%h strobe=%b exp port5=c3 strobe=00100000", out_port, out_strobe);
        end
        tick();
        checks++;
        if (out_strobe !== 8'd0 || out_port[47:40] !== 8'hC3) begin
            failures++; $display("FAIL port5_hold strobe=%b port5=%h exp 0/c3", out_strobe, out_port[47:40]);
        end
    endtask

    task automatic test_back_to_back();
        wr = 1'b1; od = 8'hA5; alu_result = 8'h77; lrn = 1'b1; ern = 1'b1; rn_sel = 3'd6; lop = 1'b1; port_sel = 3'd2;
        mem_q.push_back({8'hA5, 8'h77});
        tick();
        check_mem_txn("direct_txn");
        checks++;
        if (rn_we !== 1'b1 || rn_addr !== 3'd6 || rn_wdata !== 8'h77 || out_strobe !== 8'b0000_0100 || out_port[23:16] !== 8'h77) begin
            failures++; $display("FAIL wr_with_wb rn=%b/%0d/%h strobe=%b port2=%h exp 1/6/77 00000100 77", rn_we, rn_addr, rn_wdata, out_strobe, out_port[23:16]);
        end
        mem_ack = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (mem_we !== 1'b0 || rn_we !== 1'b0 || out_strobe !== 8'd0) begin
            failures++; $display("FAIL one_cycle_write we=%b rn_we=%b strobe=%b exp 0/0/0", mem_we, rn_we, out_strobe);
        end
        wr = 1'b1; od = 8'h10; alu_result = 8'h20;
        mem_q.push_back({8'h10, 8'h20});
        tick();
        check_mem_txn("b2b_txn");
        wr = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL b2b_done we=%b exp=0", mem_we); end
    endtask

    task automatic test_reset_mid_write();
        wr = 1'b1; od = 8'h55; alu_result = 8'h66;
        mem_q.push_back({8'h55, 8'h66});
        tick();
        wr = 1'b0;
        check_mem_txn("abort_txn");
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || stall !== 1'b0 || sp !== 8'hFF) begin
            failures++; $display("FAIL async_reset we=%b stall=%b sp=%h exp 0/0/ff", mem_we, stall, sp);
        end
`ifdef STACK_GUARD_EN
        checks++;
        if (sp_fault !== 1'b0) begin failures++; $display("FAIL fault_clear fault=%b exp=0", sp_fault); end
`endif
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (mem_we !== 1'b0 || mem_q.size() != 0) begin
            failures++; $display("FAIL no_retry we=%b pending=%0d exp 0/0", mem_we, mem_q.size());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_push();
        test_pop();
        test_wrap();
        test_priority_output();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
